player_shot_ctrl: RTL and testbench

Controller that sequences the player's single missile: it accepts a fire request from the keyboard keycode, launches the missile from the player's current X position, and steps it upward once per frame. It resolves hits reported by the collision logic, times the explosion sprite, and enforces a reload cooldown before the next shot. It sits between the keyboard interface and player position on one side and the sprite renderer and collision/score logic on the other. It owns the only player-missile resource.

---
 rtl/player_shot_ctrl.sv | 134 +++++++++++++
 tb/tb_player_shot_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl
//   Sequences the player's single missile: launches on a fresh fire keypress,
//   climbs Y_STEP pixels per frame, resolves hits from the collision logic,
//   times the explosion sprite and enforces a reload cooldown.
//
// Ports
//   frame_clk         in   frame clock, one rising edge per frame
//   Reset             in   asynchronous, active-high reset
//   keycode    [7:0]  in   current keycode from the keyboard interface
//   player_X   [9:0]  in   current player X position
//   hit               in   missile overlaps a target this frame
//   missile_X  [9:0]  out  missile X (fixed during flight)
//   missile_Y  [9:0]  out  missile Y
//   missile_active    out  high while the missile is in flight
//   missile_exploding out  high while the explosion is shown
//   shot_fired        out  one-frame pulse on launch
//   hit_ack           out  one-frame pulse per accepted hit
module player_shot_ctrl #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] X_OFFSET        = 10'd12,
  parameter logic [9:0] Y_START         = 10'd440,
  parameter logic [9:0] Y_MIN           = 10'd16,
  parameter logic [9:0] Y_STEP          = 10'd4,
  parameter int         EXPLODE_FRAMES  = 8,
  parameter int         COOLDOWN_FRAMES = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] player_X,
  input  logic       hit,
  output logic [9:0] missile_X,
  output logic [9:0] missile_Y,
  output logic       missile_active,
  output logic       missile_exploding,
  output logic       shot_fired,
  output logic       hit_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    EXPLODE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Below this Y another step would pass Y_MIN, so the missile tops out instead.
  localparam logic [9:0] Y_TOP       = Y_MIN + Y_STEP;
  localparam logic [7:0] EXPLODE_LD  = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_LD = 8'(COOLDOWN_FRAMES - 1);

  state_t     state;
  logic [7:0] counter;
  logic [7:0] key_prev;
  logic       fire_req;

  // Rising edge of the fire key only: a held key fires once.
  assign fire_req = (keycode == FIRE_KEY) && (key_prev != FIRE_KEY);

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state             <= IDLE;
      counter           <= '0;
      key_prev          <= '0;
      missile_X         <= '0;
      missile_Y         <= '0;
      missile_active    <= 1'b0;
      missile_exploding <= 1'b0;
      shot_fired        <= 1'b0;
      hit_ack           <= 1'b0;
    end else begin
      key_prev   <= keycode;
      shot_fired <= 1'b0;
      hit_ack    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (fire_req) begin
            state          <= FLIGHT;
            missile_X      <= player_X + X_OFFSET;  // wraps modulo 1024
            missile_Y      <= Y_START;
            missile_active <= 1'b1;
            shot_fired     <= 1'b1;
          end
        end

        FLIGHT: begin
          // A hit takes priority over topping out, so a hit on the last
          // frame of flight is still scored.
          if (hit) begin
            state             <= EXPLODE;
            counter           <= EXPLODE_LD;
            missile_active    <= 1'b0;
            missile_exploding <= 1'b1;
            hit_ack           <= 1'b1;
          end else if (missile_Y < Y_TOP) begin
            state             <= EXPLODE;
            counter           <= EXPLODE_LD;
            missile_active    <= 1'b0;
            missile_exploding <= 1'b1;
          end else begin
            missile_Y <= missile_Y - Y_STEP;
          end
        end

        EXPLODE: begin
          if (counter == '0) begin
            state             <= COOLDOWN;
            counter           <= COOLDOWN_LD;
            missile_exploding <= 1'b0;
          end else begin
            counter <= counter - 8'd1;
          end
        end

        COOLDOWN: begin
          // Presses here are consumed through key_prev and never queued.
          if (counter == '0) begin
            state <= IDLE;
          end else begin
            counter <= counter - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Self-checking bench for player_shot_ctrl: directed steps from the test plan
// followed by a randomized run, all compared against a frame-level model.
module tb_player_shot_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] player_X;
  logic       hit;
  logic [9:0] missile_X;
  logic [9:0] missile_Y;
  logic       missile_active;
  logic       missile_exploding;
  logic       shot_fired;
  logic       hit_ack;

  player_shot_ctrl dut (
    .frame_clk         (frame_clk),
    .Reset             (Reset),
    .keycode           (keycode),
    .player_X          (player_X),
    .hit               (hit),
    .missile_X         (missile_X),
    .missile_Y         (missile_Y),
    .missile_active    (missile_active),
    .missile_exploding (missile_exploding),
    .shot_fired        (shot_fired),
    .hit_ack           (hit_ack)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: mode is what the player sees (0 idle, 1 flying,
  // 2 exploding, 3 reloading); frames_left counts frames still to show.
  int m_mode, m_left, m_x, m_y, m_shot, m_ack, m_prev;
  int shots_seen = 0;
  int acks_seen  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_x = 0; m_y = 0; m_shot = 0; m_ack = 0; m_prev = 0;
  endtask

  task automatic model_edge();
    bit fire;
    fire   = (keycode == 8'h2C) && (m_prev != 'h2C);
    m_shot = 0;
    m_ack  = 0;
    case (m_mode)
      0: if (fire) begin
           m_x = (int'(player_X) + 12) % 1024;
           m_y = 440; m_shot = 1; m_mode = 1;
         end
      1: if (hit) begin
           m_mode = 2; m_left = 8; m_ack = 1;
         end else if (m_y - 4 < 16) begin
           m_mode = 2; m_left = 8;
         end else begin
           m_y = m_y - 4;
         end
      2: begin
           m_left--;
           if (m_left == 0) begin m_mode = 3; m_left = 15; end
         end
      default: begin
           m_left--;
           if (m_left == 0) m_mode = 0;
         end
    endcase
    m_prev = int'(keycode);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_x"},    32'(missile_X),         32'(m_x));
    check({tag, "_y"},    32'(missile_Y),         32'(m_y));
    check({tag, "_act"},  32'(missile_active),    32'(m_mode == 1));
    check({tag, "_expl"}, 32'(missile_exploding), 32'(m_mode == 2));
    check({tag, "_shot"}, 32'(shot_fired),        32'(m_shot));
    check({tag, "_ack"},  32'(hit_ack),           32'(m_ack));
  endtask

  task automatic step(input string tag, input logic [7:0] kc, input logic [9:0] px, input logic h);
    keycode  = kc;
    player_X = px;
    hit      = h;
    @(posedge frame_clk);
    model_edge();
    #1;
    compare_all(tag);
    if (shot_fired === 1'b1) shots_seen++;
    if (hit_ack === 1'b1) acks_seen++;
  endtask

  initial begin
    int s0, a0;

    // Reset state
    Reset = 1'b1; keycode = '0; player_X = '0; hit = 1'b0;
    model_reset();
    #3;
    compare_all("reset");
    @(negedge frame_clk);
    Reset = 1'b0;

    // Launch from player_X=320, key held through a whole shot cycle
    s0 = shots_seen; a0 = acks_seen;
    step("launch", 8'h2C, 10'd320, 1'b0);
    check("launch_x_const", 32'(missile_X), 32'd332);
    check("launch_y_const", 32'(missile_Y), 32'd440);
    check("launch_shot_const", 32'(shot_fired), 32'd1);
    for (int i = 0; i < 106; i++) step("held_flight", 8'h2C, 10'(i * 7), 1'b0);
    check("top_y_const", 32'(missile_Y), 32'd16);
    check("top_x_fixed", 32'(missile_X), 32'd332);
    step("topout", 8'h2C, 10'd5, 1'b0);
    check("topout_expl_const", 32'(missile_exploding), 32'd1);
    for (int i = 0; i < 7; i++) step("held_expl", 8'h2C, 10'd5, 1'b0);
    step("held_cd_entry", 8'h2C, 10'd5, 1'b0);
    check("cd_entry_expl", 32'(missile_exploding), 32'd0);
    for (int i = 0; i < 19; i++) step("held_cd_idle", 8'h2C, 10'd5, 1'b0);
    check("held_one_shot", 32'(shots_seen - s0), 32'd1);
    check("topout_no_ack", 32'(acks_seen - a0), 32'd0);

    // Release one frame, press again in IDLE
    step("release", 8'h00, 10'd100, 1'b0);
    step("repress", 8'h2C, 10'd100, 1'b0);
    check("repress_x_const", 32'(missile_X), 32'd112);

    // Hit at Y=300 with presses toggled during flight
    s0 = shots_seen;
    for (int i = 0; i < 200 && m_y != 300; i++)
      step("hit_fly", (i % 2 == 0) ? 8'h00 : 8'h2C, 10'd900, 1'b0);
    step("hit", 8'h00, 10'd900, 1'b1);
    check("hit_ack_const", 32'(hit_ack), 32'd1);
    check("hit_y_const", 32'(missile_Y), 32'd300);
    check("hit_act_const", 32'(missile_active), 32'd0);
    step("hit_in_expl", 8'h2C, 10'd900, 1'b1);
    check("hit_in_expl_ack", 32'(hit_ack), 32'd0);
    for (int i = 0; i < 6; i++) step("expl_press", (i % 2 == 0) ? 8'h00 : 8'h2C, 10'd1, 1'b1);
    for (int i = 0; i < 12; i++) step("cd_press", (i % 2 == 0) ? 8'h00 : 8'h2C, 10'd1, 1'b0);
    // Press in late cooldown held into IDLE must not fire
    for (int i = 0; i < 8; i++) step("cd_hold_idle", 8'h2C, 10'd1, 1'b0);
    check("blocked_no_shots", 32'(shots_seen - s0), 32'd0);

    // Reset mid-flight at Y=200
    step("rst_rel", 8'h00, 10'd40, 1'b0);
    step("rst_fire", 8'h2C, 10'd40, 1'b0);
    for (int i = 0; i < 200 && m_y != 200; i++) step("rst_fly", 8'h2C, 10'd40, 1'b0);
    check("rst_at_200", 32'(missile_Y), 32'd200);
    Reset = 1'b1;
    model_reset();
    #1;
    compare_all("rst_mid");
    check("rst_mid_y_const", 32'(missile_Y), 32'd0);
    keycode = 8'h00;
    @(negedge frame_clk);
    Reset = 1'b0;
    step("post_rst_idle", 8'h00, 10'd50, 1'b0);
    step("post_rst_fire", 8'h2C, 10'd50, 1'b0);
    check("post_rst_x_const", 32'(missile_X), 32'd62);

    // Hit coinciding with top-out is counted; X wraps modulo 1024
    for (int i = 0; i < 150 && m_mode != 0; i++) step("drain", 8'h00, 10'd0, 1'b0);
    step("wrap_fire", 8'h2C, 10'd1020, 1'b0);
    check("wrap_x_const", 32'(missile_X), 32'd8);
    for (int i = 0; i < 200 && m_y != 16; i++) step("wrap_fly", 8'h00, 10'd0, 1'b0);
    step("top_hit", 8'h00, 10'd0, 1'b1);
    check("top_hit_ack_const", 32'(hit_ack), 32'd1);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] kc;
      int r;
      r  = $urandom_range(0, 9);
      kc = (r < 5) ? 8'h2C : ((r < 8) ? 8'h00 : 8'($urandom));
      step("rand", kc, 10'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
